tensor_stream_tx: RTL and testbench

TENSOR_STREAM_TX -- requirements
Module: tensor_stream_tx

---
 rtl/tensor_stream_tx.sv | 126 ++++++++++++
 tb/tb_tensor_stream_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_stream_tx.sv
// tensor_stream_tx: streams rows*cols*channels SRAM elements out as AXI-Stream beats.
// Define TENSOR_TX_CHECKSUM_EN to add a 16-bit running checksum output.
module tensor_stream_tx #(
    parameter int ADDR_WIDTH = 18,
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int MAX_CHANNELS = 64,
    parameter int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1)
) (
    input  logic m00_axis_aclk,
    input  logic m00_axis_areset,
    input  logic start,
    input  logic [ADDR_WIDTH-1:0] cfg_rows,
    input  logic [ADDR_WIDTH-1:0] cfg_cols,
    input  logic [NUM_CHANNELS_WIDTH-1:0] cfg_channels,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    output logic mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] mem_rd_data,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic m00_axis_tvalid,
    input  logic m00_axis_tready,
    output logic m00_axis_tlast,
    output logic [2*ADDR_WIDTH+NUM_CHANNELS_WIDTH-1:0] m00_axis_tuser,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic busy,
    output logic done,
    output logic err
`ifdef TENSOR_TX_CHECKSUM_EN
    , output logic [15:0] checksum
`endif
);
    localparam int UW = 2*ADDR_WIDTH + NUM_CHANNELS_WIDTH;
    localparam int CW = ADDR_WIDTH + 1;
    typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, FINISH} state_t;
    state_t state, nxt;
    logic [UW-1:0] prod;
    logic [CW-1:0] total, rd_cnt, ld_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [C_AXIS_TDATA_WIDTH-1:0] f0, f1;
    logic [1:0] cnt;
    logic pend, bad, accept, issue, take, load, pop, push, fire;

    assign prod = UW'(cfg_rows) * UW'(cfg_cols) * UW'(cfg_channels);
    assign bad = prod == '0 || prod > (UW'(1) << ADDR_WIDTH);
    assign accept = state == IDLE && start;
    // pend is the read issued last cycle; its data lands this cycle
    assign issue = (state == PREFETCH || state == STREAM) && rd_cnt != total && cnt + {1'b0, pend} < 2'd2;
    assign take = !m00_axis_tvalid || m00_axis_tready;
    assign load = take && (cnt != 2'd0 || pend);
    assign pop = take && cnt != 2'd0;
    assign push = pend && !(take && cnt == 2'd0);
    assign fire = m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;
    assign busy = state != IDLE;
    assign done = state == FINISH;
    assign mem_rd_en = issue;
    assign mem_rd_addr = addr;
    assign m00_axis_tstrb = '1;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = accept && !bad ? PREFETCH : IDLE;
            PREFETCH: nxt = STREAM;
            STREAM:   nxt = fire ? FINISH : STREAM;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset)
        if (m00_axis_areset) state <= IDLE;
        else state <= nxt;

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            err <= 1'b0;
            total <= '0;
            rd_cnt <= '0;
            ld_cnt <= '0;
            addr <= '0;
            pend <= 1'b0;
            cnt <= 2'd0;
            f0 <= '0;
            f1 <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast <= 1'b0;
            m00_axis_tdata <= '0;
            m00_axis_tuser <= '0;
        end else begin
            err <= accept && bad;
            if (accept && !bad) begin
                total <= prod[CW-1:0];
                m00_axis_tuser <= {cfg_rows, cfg_cols, cfg_channels};
                addr <= cfg_base_addr;
                rd_cnt <= '0;
                ld_cnt <= '0;
            end
            if (issue) begin
                addr <= addr + 1'b1;
                rd_cnt <= rd_cnt + 1'b1;
            end
            pend <= issue;
            if (take) begin
                m00_axis_tvalid <= load;
                m00_axis_tlast <= load && ld_cnt == total - 1'b1;
            end
            if (load) begin
                m00_axis_tdata <= cnt != 2'd0 ? f0 : mem_rd_data;
                ld_cnt <= ld_cnt + 1'b1;
            end
            // fresh data bypasses the FIFO when it is empty and the output is free
            if (pop) f0 <= f1;
            if (push) begin
                if (cnt - {1'b0, pop} == 2'd0) f0 <= mem_rd_data;
                else f1 <= mem_rd_data;
            end
            cnt <= cnt - {1'b0, pop} + {1'b0, push};
        end
    end

`ifdef TENSOR_TX_CHECKSUM_EN
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset)
        if (m00_axis_areset) checksum <= '0;
        else if (accept && !bad) checksum <= '0;
        else if (m00_axis_tvalid && m00_axis_tready) checksum <= checksum + 16'(signed'(m00_axis_tdata));
`endif
endmodule

// File: tb/tb_tensor_stream_tx.sv
// tb_tensor_stream_tx: table-driven transfers against an SRAM model plus reset corner sequences.
module tb_tensor_stream_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [17:0] cfg_rows = '0, cfg_cols = '0, cfg_base_addr = '0;
    logic [6:0] cfg_channels = '0;
    logic mem_rd_en;
    logic [17:0] mem_rd_addr;
    logic [7:0] mem_rd_data = 8'hEE;
    logic [7:0] tdata;
    logic tvalid, tlast, busy, done, err;
    logic tready = 1'b1;
    logic [42:0] tuser;
    logic [0:0] tstrb;
`ifdef TENSOR_TX_CHECKSUM_EN
    logic [15:0] checksum;
`endif
    logic [7:0] sram [0:262143];
    int n_cmp = 0, n_bad = 0;

    tensor_stream_tx dut (
        .m00_axis_aclk(clk), .m00_axis_areset(rst), .start(start),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_channels(cfg_channels), .cfg_base_addr(cfg_base_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .m00_axis_tdata(tdata), .m00_axis_tvalid(tvalid), .m00_axis_tready(tready),
        .m00_axis_tlast(tlast), .m00_axis_tuser(tuser), .m00_axis_tstrb(tstrb),
        .busy(busy), .done(done), .err(err)
`ifdef TENSOR_TX_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    // read data is valid only in the cycle after the request
    always @(posedge clk) mem_rd_data <= mem_rd_en ? sram[mem_rd_addr] : 8'hEE;

    typedef struct {
        int rows, cols, ch, base, mode;
        bit exp_err, repulse, start_at_done;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int m, input int c);
        return m == 0 ? 1'b1 : m == 1 ? (c % 3 == 1) : (c > 12);
    endfunction

    task automatic run(input vec_t v);
        int total, beats, rds, c, first_v;
        logic [17:0] ra;
        logic held, hl, quiet;
        logic [7:0] hd;
        logic [42:0] hu;
        logic [15:0] sum;
        total = v.rows * v.cols * v.ch;
        @(posedge clk); #1;
        cfg_rows = 18'(v.rows); cfg_cols = 18'(v.cols); cfg_channels = 7'(v.ch); cfg_base_addr = 18'(v.base);
        start = 1'b1; tready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (v.exp_err) begin
            @(negedge clk);
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_rd_en", mem_rd_en, 0);
            quiet = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (err || mem_rd_en || tvalid || busy) quiet = 1'b0;
            end
            chk("err_quiet", quiet, 1);
            return;
        end
        beats = 0; rds = 0; c = 1; first_v = -1; held = 1'b0; sum = '0;
        hd = '0; hl = 1'b0; hu = '0;
        forever begin
            tready = rdy(v.mode, c);
            start = v.repulse && c == 4;
            if (start) begin
                cfg_rows = 18'd3; cfg_cols = 18'd5; cfg_channels = 7'd2; cfg_base_addr = 18'h3000;
            end
            @(negedge clk);
            if (c == 1) begin
                chk("first_rd_en", mem_rd_en, 1);
                chk("busy", busy, 1);
            end
            if (mem_rd_en) begin
                ra = 18'(v.base) + 18'(rds);
                chk("rd_addr", mem_rd_addr, ra);
                rds++;
            end
            if (held) begin
                chk("stall_tvalid", tvalid, 1);
                chk("stall_tdata", tdata, hd);
                chk("stall_tlast", tlast, hl);
                chk("stall_tuser", tuser, hu);
            end
            if (tvalid && first_v < 0) begin
                first_v = c;
                if (v.mode == 0) chk("first_tvalid_cycle", c, 3);
            end
            if (tvalid && tready) begin
                ra = 18'(v.base) + 18'(beats);
                chk("tdata", tdata, sram[ra]);
                chk("tlast", tlast, beats == total - 1);
                chk("tuser", tuser, {18'(v.rows), 18'(v.cols), 7'(v.ch)});
                chk("tstrb", tstrb, 1);
                if (v.mode == 0) chk("no_bubble", c, 3 + beats);
                sum = sum + {{8{sram[ra][7]}}, sram[ra]};
                beats++;
            end
            held = tvalid && !tready;
            hd = tdata; hl = tlast; hu = tuser;
            if (beats == total) break;
            if (done) chk("early_done", done, 0);
            c++;
            if (c > 2000) begin
                n_bad++;
                $display("FAIL timeout: %0d of %0d beats", beats, total);
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        tready = 1'b1;
        start = v.start_at_done;
        cfg_rows = 18'd1; cfg_cols = 18'd2; cfg_channels = 7'd1; cfg_base_addr = 18'h50;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_no_tvalid", tvalid, 0);
        chk("read_count", rds, total);
`ifdef TENSOR_TX_CHECKSUM_EN
        chk("checksum", checksum, sum);
`endif
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_single", done, 0);
        chk("idle_busy", busy, 0);
        if (v.start_at_done) begin
            quiet = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (busy || mem_rd_en || tvalid || err) quiet = 1'b0;
            end
            chk("start_at_done_ignored", quiet, 1);
        end
    endtask

    task automatic reset_mid;
        int hs, c;
        logic quiet;
        @(posedge clk); #1;
        cfg_rows = 18'd1; cfg_cols = 18'd8; cfg_channels = 7'd1; cfg_base_addr = 18'h20;
        start = 1'b1; tready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hs = 0; c = 0;
        while (hs < 2 && c < 50) begin
            @(negedge clk);
            if (tvalid && tready) hs++;
            c++;
        end
        chk("reset_mid_reached_beat2", hs, 2);
        #2 rst = 1'b1;
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tuser", tuser, 0);
        chk("rst_rd_addr", mem_rd_addr, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tvalid || mem_rd_en || busy || done) quiet = 1'b0;
        end
        chk("no_beats_after_reset", quiet, 1);
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) sram[i] = 8'((i * 7 + 3) & 255);
        for (int i = 0; i < 6; i++) sram[16 + i] = 8'(i + 1);
        sram[18'h3FFFE] = 8'hA1; sram[18'h3FFFF] = 8'hB2; sram[0] = 8'hC3; sram[1] = 8'hD4;
        sram[18'h100] = 8'hFF; sram[18'h101] = 8'h02; sram[18'h102] = 8'hFD; sram[18'h103] = 8'h04;
        vecs[0]  = '{2, 3, 1, 'h10, 0, 0, 0, 0};
        vecs[1]  = '{2, 3, 1, 'h10, 1, 0, 0, 0};
        vecs[2]  = '{0, 3, 1, 'h10, 0, 1, 0, 0};
        vecs[3]  = '{512, 512, 2, 0, 0, 1, 0, 0};
        vecs[4]  = '{1, 4, 1, 'h3FFFE, 0, 0, 0, 0};
        vecs[5]  = '{1, 4, 1, 'h3FFFE, 2, 0, 0, 0};
        vecs[6]  = '{1, 8, 1, 'h20, 0, 0, 1, 0};
        vecs[7]  = '{2, 2, 2, 'h30, 1, 0, 0, 1};
        vecs[8]  = '{1, 4, 1, 'h100, 0, 0, 0, 0};
        vecs[9]  = '{1, 1, 0, 'h10, 0, 1, 0, 0};
        vecs[10] = '{1, 1, 1, 'h44, 0, 0, 0, 0};
        #12;
        chk("reset_tvalid", tvalid, 0);
        chk("reset_tlast", tlast, 0);
        chk("reset_rd_en", mem_rd_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_tdata", tdata, 0);
        chk("reset_tuser", tuser, 0);
        chk("reset_rd_addr", mem_rd_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 11; i++) run(vecs[i]);
        reset_mid();
        run(vecs[0]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
